// File: rtl/writeback_port_arbiter.sv
// Register-file write-port arbiter: per-pipeline result FIFOs drained onto NUM_PORT
// write ports in round-robin order. rst is asynchronous and active-low.
module writeback_port_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_PORT       = 2,
    parameter int QUEUE_DEPTH    = 2,
    parameter int PREG_NUM_WIDTH = 7,
    parameter int DATA_WIDTH     = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 reqValid,
    input  logic [NUM_REQ*PREG_NUM_WIDTH-1:0]  reqRegNum,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]      reqData,
    output logic [NUM_REQ-1:0]                 reqReady,
    output logic [NUM_PORT-1:0]                wrEnable,
    output logic [NUM_PORT*PREG_NUM_WIDTH-1:0] wrRegNum,
    output logic [NUM_PORT*DATA_WIDTH-1:0]     wrData,
    output logic [NUM_REQ-1:0]                 pending
);
    // Handshake: a result is taken at a rising edge exactly when reqValid[i] and reqReady[i]
    // are both high; reqReady depends only on the registered count, never on this cycle's grant.
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW    = PREG_NUM_WIDTH;
    localparam int DW    = DATA_WIDTH;

    logic [PTR_W-1:0] headPtr [NUM_REQ];
    logic [PTR_W-1:0] tailPtr [NUM_REQ];
    logic [CNT_W-1:0] count   [NUM_REQ];
    logic [PW-1:0]    regMem  [NUM_REQ][QUEUE_DEPTH];
    logic [DW-1:0]    dataMem [NUM_REQ][QUEUE_DEPTH];
    logic [PW-1:0]    headReg [NUM_REQ];
    logic [DW-1:0]    headData[NUM_REQ];

    logic [REQ_W-1:0]   rrPtr;
    logic [REQ_W-1:0]   rrPtrNext;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] enq;
    int                 numGrant;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqReady[i] = (count[i] < CNT_W'(QUEUE_DEPTH));
            pending[i]  = (count[i] != '0);
            headReg[i]  = regMem[i][headPtr[i]];
            headData[i] = dataMem[i][headPtr[i]];
        end
    end

    assign enq = reqValid & reqReady;

    // Visit requesters in order rrPtr, rrPtr+1, ...; the k-th non-empty one takes port k.
    always_comb begin
        grant     = '0;
        wrEnable  = '0;
        wrRegNum  = '0;
        wrData    = '0;
        rrPtrNext = rrPtr;
        numGrant  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((int'(rrPtr) + k == i) || (int'(rrPtr) + k == i + NUM_REQ)) begin
                    if (pending[i] && (numGrant < NUM_PORT)) begin
                        grant[i] = 1'b1;
                        for (int p = 0; p < NUM_PORT; p++) begin
                            if (numGrant == p) begin
                                wrEnable[p]          = 1'b1;
                                wrRegNum[p*PW +: PW] = headReg[i];
                                wrData[p*DW +: DW]   = headData[i];
                            end
                        end
                        rrPtrNext = REQ_W'((i + 1) % NUM_REQ);
                        numGrant  = numGrant + 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rrPtr <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                headPtr[i] <= '0;
                tailPtr[i] <= '0;
                count[i]   <= '0;
            end
        end else begin
            rrPtr <= rrPtrNext;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (enq[i]) begin
                    tailPtr[i] <= tailPtr[i] + 1'b1;
                end
                if (grant[i]) begin
                    headPtr[i] <= headPtr[i] + 1'b1;
                end
                if (enq[i] && !grant[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!enq[i] && grant[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
        end
    end

    // Storage is not reset; an entry is only read while its count covers it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (enq[i]) begin
                regMem[i][tailPtr[i]]  <= reqRegNum[i*PW +: PW];
                dataMem[i][tailPtr[i]] <= reqData[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_writeback_port_arbiter.sv
// Directed bench for writeback_port_arbiter: a queue-based scoreboard of accepted
// results plus fixed expectations for reset, latency, round-robin order and wrap.
module tb_writeback_port_arbiter;
    localparam int NR = 4;
    localparam int NP = 2;
    localparam int QD = 2;
    localparam int PW = 7;
    localparam int DW = 32;
    localparam int W  = PW + DW;

    logic            clk;
    logic            rst;
    logic [NR-1:0]    reqValid;
    logic [NR*PW-1:0] reqRegNum;
    logic [NR*DW-1:0] reqData;
    logic [NR-1:0]    reqReady;
    logic [NP-1:0]    wrEnable;
    logic [NP*PW-1:0] wrRegNum;
    logic [NP*DW-1:0] wrData;
    logic [NR-1:0]    pending;

    logic [W-1:0] exp_q[NR][$];
    int           m_cnt[NR];
    int           m_rr;
    logic [NR-1:0] hold;
    int           checks;
    int           errors;
    logic         saw_not_ready0;

    writeback_port_arbiter #(
        .NUM_REQ(NR), .NUM_PORT(NP), .QUEUE_DEPTH(QD),
        .PREG_NUM_WIDTH(PW), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqRegNum(reqRegNum), .reqData(reqData),
        .reqReady(reqReady),
        .wrEnable(wrEnable), .wrRegNum(wrRegNum), .wrData(wrData),
        .pending(pending)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic set_req(input int i, input logic [PW-1:0] r, input logic [DW-1:0] d);
        reqRegNum[i*PW +: PW] = r;
        reqData[i*DW +: DW]   = d;
    endtask

    task automatic drive_all(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) begin
            if (!hold[i]) begin
                set_req(i, PW'($urandom_range(0, 127)), {4'(i), 28'($urandom)});
            end
        end
        reqValid = v;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: checks this cycle's outputs, then commits the model for the coming edge
    task automatic sample();
        int port_req[NP];
        int ng;
        int last_r;
        int r;
        logic [NR-1:0] acc;
        logic [W-1:0] e;
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("reqReady[%0d]", i), 64'(reqReady[i]), 64'(m_cnt[i] < QD));
            chk($sformatf("pending[%0d]", i), 64'(pending[i]), 64'(m_cnt[i] != 0));
            acc[i] = reqValid[i] && (m_cnt[i] < QD);
        end
        if (!reqReady[0]) saw_not_ready0 = 1'b1;
        ng = 0;
        last_r = -1;
        for (int p = 0; p < NP; p++) port_req[p] = -1;
        for (int k = 0; k < NR; k++) begin
            r = (m_rr + k) % NR;
            if (m_cnt[r] != 0 && ng < NP) begin
                port_req[ng] = r;
                ng++;
                last_r = r;
            end
        end
        for (int p = 0; p < NP; p++) begin
            if (port_req[p] >= 0) begin
                chk($sformatf("wrEnable[%0d]", p), 64'(wrEnable[p]), 64'(1));
                e = exp_q[port_req[p]].pop_front();
                chk($sformatf("port%0d_result_req%0d", p, port_req[p]),
                    64'({wrRegNum[p*PW +: PW], wrData[p*DW +: DW]}), 64'(e));
                m_cnt[port_req[p]]--;
            end else begin
                chk($sformatf("wrEnable[%0d]", p), 64'(wrEnable[p]), 64'(0));
                chk($sformatf("idle_port%0d", p),
                    64'({wrRegNum[p*PW +: PW], wrData[p*DW +: DW]}), 64'(0));
            end
        end
        if (last_r >= 0) m_rr = (last_r + 1) % NR;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) begin
                exp_q[i].push_back({reqRegNum[i*PW +: PW], reqData[i*DW +: DW]});
                m_cnt[i]++;
            end
            hold[i] = reqValid[i] && !acc[i];
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) begin
            exp_q[i].delete();
            m_cnt[i] = 0;
        end
        hold = '0;
        m_rr = 0;
    endtask

    task automatic idle_cycles(input int n);
        reqValid = '0;
        for (int c = 0; c < n; c++) begin
            sample();
            advance();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        saw_not_ready0 = 1'b0;
        rst = 1'b0;
        reqRegNum = '0;
        reqData = '0;
        model_reset();

        // reset held with every requester offering
        reqValid = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wrEnable", 64'(wrEnable), 64'(0));
        chk("rst_wrRegNum", 64'(wrRegNum), 64'(0));
        chk("rst_wrData", 64'(wrData), 64'(0));
        chk("rst_reqReady", 64'(reqReady), 64'(4'b1111));
        chk("rst_pending", 64'(pending), 64'(0));
        reqValid = '0;
        rst = 1'b1;
        advance();

        // single requester latency: req 2, reg 5, 0xDEADBEEF
        set_req(2, 7'd5, 32'hDEADBEEF);
        reqValid = 4'b0100;
        sample();
        chk("lat_no_passthrough", 64'(wrEnable), 64'(0));
        advance();
        reqValid = '0;
        sample();
        chk("lat_wrEnable", 64'(wrEnable), 64'(2'b01));
        chk("lat_wrRegNum", 64'(wrRegNum[PW-1:0]), 64'(5));
        chk("lat_wrData", 64'(wrData[DW-1:0]), 64'(32'hDEADBEEF));
        chk("lat_port1_idle", 64'({wrRegNum[2*PW-1:PW], wrData[2*DW-1:DW]}), 64'(0));
        chk("lat_pending", 64'(pending), 64'(4'b0100));
        advance();
        sample();
        chk("lat_pending_after", 64'(pending), 64'(0));
        advance();

        // round-robin fairness from reset, all requesters continuously offering
        rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        drive_all(4'b1111);
        sample();
        advance();
        for (int c = 0; c < 3; c++) begin
            drive_all(4'b1111);
            sample();
            chk($sformatf("rr_c%0d_en", c), 64'(wrEnable), 64'(2'b11));
            chk($sformatf("rr_c%0d_p0", c), 64'(wrData[28 +: 4]), 64'((c % 2 == 0) ? 0 : 2));
            chk($sformatf("rr_c%0d_p1", c), 64'(wrData[DW+28 +: 4]), 64'((c % 2 == 0) ? 1 : 3));
            advance();
        end
        // keep all four busy: req 0 must be pushed back and still lose nothing
        for (int c = 0; c < 12; c++) begin
            drive_all(4'b1111);
            sample();
            advance();
        end
        chk("req0_backpressure_seen", 64'(saw_not_ready0), 64'(1));
        idle_cycles(4);

        // pointer skip: leave rrPtr at 1 with only 0 and 3 non-empty
        set_req(0, 7'd10, 32'h0000_0A0A);
        reqValid = 4'b0001;
        sample();
        advance();
        set_req(0, 7'd11, 32'h0000_0B0B);
        set_req(3, 7'd33, 32'h3000_0033);
        reqValid = 4'b1001;
        sample();
        advance();
        set_req(0, 7'd12, 32'h0000_0C0C);
        set_req(1, 7'd21, 32'h1000_0021);
        reqValid = 4'b0011;
        sample();
        chk("skip_en", 64'(wrEnable), 64'(2'b11));
        chk("skip_p0_req3", 64'(wrRegNum[PW-1:0]), 64'(33));
        chk("skip_p1_req0", 64'(wrRegNum[2*PW-1:PW]), 64'(11));
        advance();
        reqValid = '0;
        sample();
        chk("skip_rr1_p0_req1", 64'(wrRegNum[PW-1:0]), 64'(21));
        chk("skip_rr1_p1_req0", 64'(wrRegNum[2*PW-1:PW]), 64'(12));
        advance();
        idle_cycles(2);

        // streaming through requester 1: simultaneous enqueue/dequeue and pointer wrap
        for (int k = 1; k <= 9; k++) begin
            if (k <= 8) begin
                set_req(1, 7'(k), {4'd1, 28'(k * 3)});
                reqValid = 4'b0010;
            end else begin
                reqValid = '0;
            end
            sample();
            if (k <= 8) chk($sformatf("stream_ready_%0d", k), 64'(reqReady[1]), 64'(1));
            if (k >= 2) chk($sformatf("stream_reg_%0d", k - 1), 64'(wrRegNum[PW-1:0]), 64'(k - 1));
            advance();
        end
        idle_cycles(2);

        // asynchronous reset in the middle of traffic
        drive_all(4'b1111);
        sample();
        advance();
        drive_all(4'b1111);
        sample();
        advance();
        reqValid = '0;
        rst = 1'b0;
        #1;
        chk("async_pending", 64'(pending), 64'(0));
        chk("async_wrEnable", 64'(wrEnable), 64'(0));
        chk("async_wrData", 64'(wrData), 64'(0));
        chk("async_reqReady", 64'(reqReady), 64'(4'b1111));
        model_reset();
        advance();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive_all(4'($urandom_range(0, 15)));
            sample();
            advance();
        end
        idle_cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
